wb_bram_responder: RTL
======================

# wb_bram_responder

Wishbone classic slave that terminates the BRAM branch of the user-area Wishbone decoder. It sits behind the 0x3800_0000 window and serves 32-bit reads and byte-lane writes from an on-chip single-port RAM. It inserts a fixed, parameterised number of wait states before acknowledging, to model exmem latency for firmware. Address decode is done upstream: this block sees only cycles already qualified by `wbs_cyc_i`.

## Interface
- `DELAYS`, 10: wait-state cycles between request capture and RAM access; legal range ≥1.
- `ADDR_WIDTH`, 12: word-address bits; RAM depth 2^ADDR_WIDTH words (default 16 KiB).
- `wb_clk_i`  in  1  single clock for the whole block.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `wbs_stb_i`  in  1  strobe.
- `wbs_cyc_i`  in  1  bus cycle valid (already gated by the decoder select).
- `wbs_we_i`  in  1  1 = write, 0 = read.
- `wbs_sel_i`  in  4  byte-lane enables; bit n covers `dat[8n+7:8n]`.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address; only `[ADDR_WIDTH+1:2]` is used.
- `wbs_ack_o`  out  1  registered single-cycle acknowledge.
- `wbs_dat_o`  out  32  registered read data; valid only while `wbs_ack_o`=1.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if `wbs_cyc_i & wbs_stb_i`, capture word address, `we`, `sel`, `dat_i`. Clear the wait counter and go to WAIT. Otherwise stay.
- WAIT: increment the counter each cycle. When the counter reaches `DELAYS-1` and `cyc` is still high, perform the RAM access and go to ACK.
  - Write: update only lanes with `sel`=1; other lanes keep their contents.
  - Read: register the full 32-bit word.
- ACK: `wbs_ack_o`=1 for exactly one cycle. `wbs_dat_o` = read word for reads and 0 for writes. Next state is IDLE.
- Abort: if `wbs_cyc_i`=0 in any WAIT cycle, return to IDLE. No RAM write is committed and no ack is issued.
- `wbs_stb_i` low in WAIT while `cyc` is high is ignored; the captured request completes.
- Back-to-back: if stb/cyc are still high in the IDLE cycle after ACK, a new transaction starts. There is never an ack in two consecutive cycles.
- Upper address bits above `ADDR_WIDTH+1` and `adr[1:0]` are ignored, so the RAM aliases across the window.
- Counter width: `$clog2(DELAYS+1)`. The counter saturates at `DELAYS-1` and never wraps within a transaction.
- Reset: state IDLE, counter 0, `wbs_ack_o`=0, `wbs_dat_o`=0. RAM contents are not cleared. Reset asserted in WAIT or ACK cancels the transaction, and a pending write is not committed.

## Timing
- Request sampled in IDLE at cycle T. WAIT occupies T+1..T+DELAYS. RAM access happens at the edge ending T+DELAYS. `wbs_ack_o`=1 in cycle T+DELAYS+1.
- Total latency is DELAYS+1 cycles from sample to ack; the default is 11.
- Throughput: one transaction per DELAYS+2 cycles with stb held continuously.
- All outputs come from flops; there is no combinational path from inputs to outputs.
- `wbs_dat_o` returns to 0 in the cycle after ack.

## Structure
- Shared package `wb_pkg`:
  - `WB_DW`=32 and `WB_SELW`=4.
  - FSM state typedef `wb_resp_state_t` {IDLE, WAIT, ACK}.
  - BRAM window base constant 0x3800_0000.
- Sub-module `bram_sp_be`: single-port synchronous RAM with parameters `ADDR_WIDTH` and 4 byte-write enables, 1-cycle read. It is instantiated once, so the FSM stays separate from the storage and the RAM can later be swapped for a hard macro.

## Test plan
- Write/read: write 0xDEADBEEF to 0x3800_0010 with sel=0xF, then read 0x3800_0010 → read ack carries 0xDEADBEEF; write ack carries 0.
- Byte lanes: preload 0x11223344 at 0x3800_0020, write 0xAABBCCDD with sel=0x5 → readback is 0x11BB33DD.
- Latency: with DELAYS=10, stb sampled at cycle 100 → ack at cycle 111 only. Rerun with DELAYS=1 → ack at T+2.
- Abort: start a write of 0xFFFFFFFF to 0x3800_0040 (previously 0), drop cyc at T+3 → no ack; a later read returns 0.
- Back-to-back and alias: hold stb/cyc for two reads of 0x3800_0010 and 0x3800_4010 (alias for ADDR_WIDTH=12) → acks at T+11 and T+23, both with the same data.
- Reset mid-operation: assert `wb_rst_i` at T+5 of a write → ack and dat are 0 next cycle, the FSM is in IDLE, and the target word is unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: bus widths, responder FSM states, BRAM window base.
// No logic of its own.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [31:0] BRAM_BASE = 32'h3800_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_resp_state_t;

endpackage

// File: rtl/bram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables; 1-cycle registered read.
// No backpressure: every enabled access completes at the next clock edge.
module bram_sp_be
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [WB_SELW-1:0]    wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DW-1:0]      wdata,
  output logic [WB_DW-1:0]      rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WB_DW-1:0] mem [DEPTH];

  // Storage is never reset so it maps onto block RAM or a hard macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_SELW; i++) begin
      if (wr_en[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_bram_responder.sv
// Wishbone classic slave over a byte-lane BRAM; ack DELAYS+1 cycles after the request is sampled.
// Holds off the master by withholding ack; dropping cyc during the wait aborts with no side effects.
module wb_bram_responder
  import wb_pkg::*;
#(
  parameter int DELAYS     = 10,
  parameter int ADDR_WIDTH = 12
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [WB_DW-1:0]   wbs_dat_o
);

  localparam int               CNT_W    = $clog2(DELAYS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS - 1);

  wb_resp_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;
  logic                  access;

  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  we_q;
  logic [WB_SELW-1:0]    sel_q;
  logic [WB_DW-1:0]      dat_q;

  logic [WB_SELW-1:0]    ram_wr_en;
  logic                  ram_rd_en;
  logic [WB_DW-1:0]      ram_rdata;

  // Address bits outside the word index are dropped, so the RAM aliases across the window.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (capture) begin
      adr_q <= wbs_adr_i[ADDR_WIDTH+1:2];
      we_q  <= wbs_we_i;
      sel_q <= wbs_sel_i;
      dat_q <= wbs_dat_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Only cyc matters here; stb may drop once the request is captured.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          access  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset on the access edge must not let a pending write land.
  assign ram_wr_en = {WB_SELW{access & we_q & ~wb_rst_i}} & sel_q;
  assign ram_rd_en = access & ~we_q;

  bram_sp_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (wb_clk_i),
    .rd_en (ram_rd_en),
    .wr_en (ram_wr_en),
    .addr  (adr_q),
    .wdata (dat_q),
    .rdata (ram_rdata)
  );

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = (state_q == ACK && !we_q) ? ram_rdata : '0;

endmodule
